// File: rtl/rv_lsu_if.sv
// rv_lsu_if: core request/response and data-bus signals of the LSU.
// slave is the LSU side, master is the core/bus side.
interface rv_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport slave (
    input  req_valid, req_we, req_func3,
    input  req_addr, req_wdata,
    input  bus_ready, bus_rvalid, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, bus_valid, bus_we,
    output bus_addr, bus_wdata, bus_be
  );

  modport master (
    output req_valid, req_we, req_func3,
    output req_addr, req_wdata,
    output bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, bus_valid, bus_we,
    input  bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/rv_lsu.sv
// rv_lsu: single-outstanding RV32I load/store unit.
// Lane steering, load extension and a bus timeout.
module rv_lsu #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 15,
  parameter bit ZERO_ON_ERR = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  rv_lsu_if.slave io
);
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE, BUS, WAIT, RESP
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_q, we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [3:0]        be_q;
  logic [CW-1:0]     cnt_q;

  logic        accept, expire;
  logic        ill, mis, req_err;
  logic        sz_b, sz_h;
  logic [3:0]  req_be;
  logic [31:0] req_wd, ld_sh, ld_data;

  assign accept = io.req_valid & rdy_q;
  assign expire = (TIMEOUT != 0) &&
                  (int'(cnt_q) == TIMEOUT - 1);

  assign sz_b = (io.req_func3[1:0] == 2'b00);
  assign sz_h = (io.req_func3[1:0] == 2'b01);

  assign ill = io.req_we ?
    (io.req_func3[2] | (&io.req_func3[1:0])) :
    ((io.req_func3 == 3'b011) |
     (io.req_func3[2:1] == 2'b11));
  assign mis = (sz_h & io.req_addr[0]) |
    ((io.req_func3[1:0] == 2'b10) &
     (io.req_addr[1:0] != 2'b00));
  assign req_err = ill | mis;

  // store byte enables and lane-replicated data
  always_comb begin
    req_be = 4'b1111;
    req_wd = io.req_wdata;
    unique case (1'b1)
      sz_b: begin
        req_be = 4'b0001 << io.req_addr[1:0];
        req_wd = {4{io.req_wdata[7:0]}};
      end
      sz_h: begin
        req_be = io.req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd = {2{io.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_sh = io.bus_rdata >> {addr_q[1:0], 3'b000};

  // load lane extraction and extension
  always_comb begin
    ld_data = ld_sh;
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_data = {24'd0, ld_sh[7:0]};
      3'b101:  ld_data = {16'd0, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

  // next state; a handshake beats timeout expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = req_err ? RESP : BUS;
      BUS: begin
        if (io.bus_ready) state_d = we_q ? RESP : WAIT;
        else if (expire)  state_d = RESP;
      end
      WAIT: begin
        if (io.bus_rvalid) state_d = RESP;
        else if (expire)   state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, captured request, counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= io.req_we;
            f3_q    <= io.req_func3;
            addr_q  <= io.req_addr;
            wdata_q <= req_wd;
            be_q    <= req_be;
            cnt_q   <= '0;
            err_q   <= req_err;
            if (req_err && ZERO_ON_ERR)
              rdata_q <= '0;
          end
        end
        BUS, WAIT: begin
          if (TIMEOUT != 0)
            cnt_q <= cnt_q + CW'(1);
          if (state_q == BUS && io.bus_ready) begin
            if (we_q) rdata_q <= '0;
          end else if (state_q == WAIT &&
                       io.bus_rvalid) begin
            rdata_q <= ld_data;
          end else if (expire) begin
            err_q <= 1'b1;
            if (ZERO_ON_ERR) rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.req_ready = rdy_q;
  assign io.rsp_valid = (state_q == RESP);
  assign io.rsp_err   = err_q & (state_q == RESP);
  assign io.rsp_rdata = rdata_q;
  assign io.bus_valid = (state_q == BUS);
  assign io.bus_we    = we_q;
  assign io.bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign io.bus_wdata = wdata_q;
  assign io.bus_be    = be_q;
endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: random and directed transactions against
// an arithmetic reference model of the LSU.
module tb_rv_lsu;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   npass = 0;

  always #5 clk = ~clk;

  rv_lsu_if #(.ADDR_W(32)) lif ();

  rv_lsu #(
    .ADDR_W(32),
    .TIMEOUT(TO),
    .ZERO_ON_ERR(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(lif)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  tag, act, exp);
  endtask

  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_err(input bit we,
                               input logic [2:0] f3,
                               input logic [31:0] a);
    bit legal;
    int off;
    if (we) legal = (f3 <= 3'd2);
    else legal = (f3 inside {3'd0, 3'd1, 3'd2,
                             3'd4, 3'd5});
    off = int'(a[1:0]);
    return !legal || (off % m_size(f3) != 0);
  endfunction

  function automatic logic [3:0] m_be(
      input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = m_size(f3);
    return 4'(((1 << s) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wd(
      input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] o;
    int s;
    s = m_size(f3);
    o = '0;
    for (int i = 0; i < 4; i++)
      o[8*i +: 8] = d[8*(i % s) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_ld(
      input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] d);
    logic [31:0] v, mask;
    int s;
    s = m_size(f3);
    v = d >> (8 * int'(a[1:0]));
    if (s < 4) begin
      mask = (32'd1 << (8 * s)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*s-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic txn(input string nm, input bit we,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rd_word,
                     input int rd, input int rv);
    bit e_err, tmo, done, hs;
    int total, e_lat, e_nb, lat, nb, nw, g;
    logic [31:0] e_rd;
    e_err = m_err(we, f3, a);
    total = e_err ? 0 : (we ? rd + 1 : rd + rv + 2);
    tmo = !e_err && (total > TO);
    e_lat = e_err ? 1 : (tmo ? TO + 1 : total + 1);
    e_nb = e_err ? 0 : ((rd + 1 < TO) ? rd + 1 : TO);
    e_rd = (e_err || tmo || we) ? 32'd0 :
           m_ld(f3, a, rd_word);
    g = 0;
    while (!lif.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({nm, " req_ready"}, 32'(lif.req_ready), 1);
    lif.req_valid = 1'b1;
    lif.req_we    = we;
    lif.req_func3 = f3;
    lif.req_addr  = a;
    lif.req_wdata = wd;
    @(negedge clk);
    lif.req_valid = 1'b0;
    lat = 1; nb = 0; nw = 0; hs = 0; done = 0;
    while (!done && lat < 60) begin
      lif.bus_ready  = 1'b0;
      lif.bus_rvalid = 1'b0;
      if (lif.rsp_valid) begin
        done = 1;
      end else begin
        if (lif.bus_valid) begin
          nb++;
          check({nm, " bus_we"}, 32'(lif.bus_we),
                32'(we));
          check({nm, " bus_addr"}, lif.bus_addr,
                a & ~32'd3);
          if (we) begin
            check({nm, " bus_be"}, 32'(lif.bus_be),
                  32'(m_be(f3, a)));
            check({nm, " bus_wdata"}, lif.bus_wdata,
                  m_wd(f3, wd));
          end
          if (nb == rd + 1) begin
            lif.bus_ready = 1'b1;
            hs = 1;
          end else if ($urandom_range(0, 3) == 0) begin
            lif.bus_rvalid = 1'b1;
            lif.bus_rdata  = $urandom;
          end
        end else if (hs) begin
          if (nw == rv) begin
            lif.bus_rvalid = 1'b1;
            lif.bus_rdata  = rd_word;
          end else begin
            lif.bus_ready = 1'($urandom_range(0, 1));
            lif.bus_rdata = $urandom;
          end
          nw++;
        end
        @(negedge clk);
        lat++;
      end
    end
    lif.bus_ready  = 1'b0;
    lif.bus_rvalid = 1'b0;
    if (!done)
      check({nm, " rsp_seen"}, 32'(lif.rsp_valid), 1);
    check({nm, " latency"}, lat, e_lat);
    check({nm, " bus_cycles"}, nb, e_nb);
    check({nm, " rsp_err"}, 32'(lif.rsp_err),
          32'(e_err || tmo));
    check({nm, " rsp_rdata"}, lif.rsp_rdata, e_rd);
    @(negedge clk);
    check({nm, " rsp_pulse"}, 32'(lif.rsp_valid), 0);
    check({nm, " bus_idle"}, 32'(lif.bus_valid), 0);
  endtask

  task automatic check_reset(input string nm);
    check({nm, " req_ready"}, 32'(lif.req_ready), 0);
    check({nm, " bus_valid"}, 32'(lif.bus_valid), 0);
    check({nm, " rsp_valid"}, 32'(lif.rsp_valid), 0);
    check({nm, " rsp_err"}, 32'(lif.rsp_err), 0);
    check({nm, " rsp_rdata"}, lif.rsp_rdata, 0);
    check({nm, " bus_be"}, 32'(lif.bus_be), 0);
  endtask

  initial begin
    bit we;
    logic [2:0] f3;
    int rd, rv;
    rst = 1'b1;
    lif.req_valid  = 1'b0;
    lif.req_we     = 1'b0;
    lif.req_func3  = 3'd0;
    lif.req_addr   = '0;
    lif.req_wdata  = '0;
    lif.bus_ready  = 1'b0;
    lif.bus_rvalid = 1'b0;
    lif.bus_rdata  = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check("por ready_after", 32'(lif.req_ready), 1);

    txn("lb_sext", 0, 3'b000, 32'h1000_0003,
        32'h0, 32'h80FF_FF12, 0, 0);
    txn("sh_hi", 1, 3'b001, 32'h2000_0002,
        32'h1234_ABCD, 32'h0, 0, 0);
    txn("lw_mis", 0, 3'b010, 32'h3000_0001,
        32'h0, 32'h0, 0, 0);
    txn("ld_tmo_bus", 0, 3'b010, 32'h4000_0000,
        32'h0, 32'h1111_2222, 19, 0);
    txn("ld_rv_at_exp", 0, 3'b101, 32'h5000_0002,
        32'h0, 32'hBEEF_7654, 0, 13);
    txn("ld_tmo_wait", 0, 3'b100, 32'h5000_0001,
        32'h0, 32'hBEEF_7654, 0, 14);
    txn("st_at_exp", 1, 3'b000, 32'h6000_0001,
        32'h0000_00A5, 32'h0, 14, 0);
    txn("st_illegal", 1, 3'b011, 32'h6000_0000,
        32'h0, 32'h0, 0, 0);

    // reset while waiting for read data
    lif.req_valid = 1'b1;
    lif.req_we    = 1'b0;
    lif.req_func3 = 3'b010;
    lif.req_addr  = 32'h0000_0100;
    @(negedge clk);
    lif.req_valid = 1'b0;
    check("rst_mid bus", 32'(lif.bus_valid), 1);
    lif.bus_ready = 1'b1;
    @(negedge clk);
    lif.bus_ready = 1'b0;
    check("rst_mid wait", 32'(lif.bus_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    lif.bus_rvalid = 1'b1;
    lif.bus_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    lif.bus_rvalid = 1'b0;
    check("rst_mid ready", 32'(lif.req_ready), 1);
    check("rst_mid no_rsp0", 32'(lif.rsp_valid), 0);
    @(negedge clk);
    check("rst_mid no_rsp1", 32'(lif.rsp_valid), 0);
    check("rst_mid no_bus", 32'(lif.bus_valid), 0);

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        f3 = 3'($urandom_range(0, 2));
      rd = ($urandom_range(0, 9) == 0) ?
           $urandom_range(10, 20) : $urandom_range(0, 3);
      rv = ($urandom_range(0, 9) == 0) ?
           $urandom_range(8, 16) : $urandom_range(0, 3);
      txn($sformatf("rnd%0d", i), we, f3, $urandom,
          $urandom, $urandom, rd, rv);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of the request and bus addresses.
REQ-002 Parameter TIMEOUT, default 15, cycles allowed in BUS+WAIT before a bus-error response; 0 disables the timeout.
REQ-003 Parameter ZERO_ON_ERR, default 1; 1 forces rsp_rdata to 0 on error; 0 holds the last rsp_rdata.
REQ-004 Clocking: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  core request valid.
REQ-008 req_ready  out  1  LSU can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_func3  in  3  RV32I funct3 (lb/lh/lw/lbu/lhu; sb/sh/sw).
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  32  store data, rs2 value.
REQ-013 rsp_valid  out  1  one-cycle response strobe.
REQ-014 rsp_rdata  out  32  extended load result; 0 for stores.
REQ-015 rsp_err  out  1  misaligned, illegal funct3 or timeout.
REQ-016 bus_valid  out  1  bus command valid.
REQ-017 bus_ready  in  1  bus accepts the command.
REQ-018 bus_we  out  1  bus write.
REQ-019 bus_addr  out  ADDR_W  word-aligned address, low 2 bits = 0.
REQ-020 bus_wdata  out  32  lane-replicated store data.
REQ-021 bus_be  out  4  byte enables.
REQ-022 bus_rvalid  in  1  read data valid.
REQ-023 bus_rdata  in  32  read data word.

Function
REQ-024 The FSM SHALL have states IDLE, BUS, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-025 In IDLE, req_valid=1 SHALL register we, func3, addr and wdata; the next state SHALL be RESP with err=1 on an error, otherwise BUS.
REQ-026 Misaligned cases: h/hu with addr[0]=1; w with addr[1:0]!=0. Illegal func3: loads 011, 110 and 111; stores any value above 010.
REQ-027 In BUS, bus_valid SHALL be 1 and all bus command outputs SHALL be stable until the cycle with bus_ready=1.
REQ-028 On a BUS handshake, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-029 In WAIT, bus_rvalid=1 SHALL capture the extracted data and move to RESP; bus_rvalid outside WAIT SHALL be ignored.
REQ-030 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE; back-to-back requests SHALL be spaced at least 1 IDLE cycle apart.
REQ-031 Store lanes: sb gives be = 1 << addr[1:0] and wdata = byte replicated x4; sh gives be = 0011 or 1100 and wdata = half replicated x2; sw gives be = 1111.
REQ-032 Load extraction: shift right by 8*addr[1:0]; lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word through.
REQ-033 The timeout counter SHALL clear on entering BUS and increment each cycle in BUS or WAIT.
REQ-034 When the counter reaches TIMEOUT, the FSM SHALL go to RESP with err=1 and drop bus_valid in the same transition.
REQ-035 If bus_ready or bus_rvalid arrives in the same cycle as timeout expiry, the handshake SHALL win and the timeout SHALL be ignored.
REQ-036 Latency from acceptance edge to rsp_valid: error 1 cycle; store with bus_ready=1, 2 cycles; load with bus_ready=1 and bus_rvalid the next cycle, 3 cycles.
REQ-037 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.

Reset
REQ-038 While rst=1: state=IDLE, counter=0, bus_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, bus_be=0.
REQ-039 Reset mid-transaction SHALL abandon the transaction without a response; a late bus_rvalid SHALL be ignored.
REQ-040 req_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.

Verification
REQ-041 lb at addr 0x...03, bus_rdata=0x80FF_FF12 -> rsp_rdata=0xFFFF_FF80, rsp_err=0.
REQ-042 sh at addr 0x...02, wdata=0x1234_ABCD -> bus_be=1100, bus_wdata=0xABCD_ABCD, rsp_rdata=0.
REQ-043 lw at addr 0x...01 -> bus_valid stays 0 and rsp_valid=1 with rsp_err=1 exactly 1 cycle after acceptance.
REQ-044 Load with bus_ready low for 20 cycles, TIMEOUT=15 -> rsp_err=1 after 15 counted cycles, bus_valid=0 from then on.
REQ-045 bus_rvalid in the same cycle as timeout expiry -> rsp_err=0 with correct data.
REQ-046 rst asserted in WAIT, then bus_rvalid arrives -> no rsp_valid, and req_ready=1 in the first cycle after rst falls.
